coarse_read_counter: RTL and testbench

Digital read-counter and coarse-switch driver for one CDU channel; sits directly upstream of the coarse error summing stage. It holds the 15-bit angle read counter, decodes its high-order bits into the coarse switch controls `_DC1`–`_DC12`, and consumes the resulting coarse threshold (`_TLC1H`) and ambiguity (`_ADHI`) indications. When coarse error persists, the block slews the counter at high rate until the coarse loop nulls, then hands control back to fine-loop counting.

---
 rtl/coarse_read_counter_if.sv | 43 ++++
 rtl/coarse_read_counter.sv | 184 ++++++++++++++++++
 tb/tb_coarse_read_counter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coarse_read_counter_if.sv
// Bundle of fine-loop requests, coarse indications and counter/switch outputs
// for one CDU coarse read-counter channel.
interface coarse_read_counter_if;
  // There is no back-pressure anywhere on this bundle: inputs are sampled on
  // every clock, and _CNTUP/_CNTDN act as the one-cycle valid qualifier for a
  // change of count (at most one change, in one direction, per cycle).
  logic        fine_up;
  logic        fine_dn;
  logic        _TLC1H;
  logic        _ADHI;
  logic        _DC1;
  logic        _DC2;
  logic        _DC3;
  logic        _DC4;
  logic        _DC5;
  logic        _DC6;
  logic        _DC7;
  logic        _DC8;
  logic        _DC9;
  logic        _DC10;
  logic        _DC11;
  logic        _DC12;
  logic [14:0] count;
  logic        _CNTUP;
  logic        _CNTDN;
  logic        slewing;
  logic        slew_err;
  logic [2:0]  state_dbg;

  modport master (
    output fine_up, fine_dn, _TLC1H, _ADHI,
    input  _DC1, _DC2, _DC3, _DC4, _DC5, _DC6, _DC7, _DC8,
    input  _DC9, _DC10, _DC11, _DC12,
    input  count, _CNTUP, _CNTDN, slewing, slew_err, state_dbg
  );

  modport slave (
    input  fine_up, fine_dn, _TLC1H, _ADHI,
    output _DC1, _DC2, _DC3, _DC4, _DC5, _DC6, _DC7, _DC8,
    output _DC9, _DC10, _DC11, _DC12,
    output count, _CNTUP, _CNTDN, slewing, slew_err, state_dbg
  );
endinterface

// File: rtl/coarse_read_counter.sv
// Coarse read counter and switch driver for one CDU channel: fine-loop counting,
// qualified coarse slewing, and optional 180-degree ambiguity jump (COARSE_AMBIG_EN).
module coarse_read_counter #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SLEW_DIV      = 4,
  parameter int SLEW_STEP     = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  coarse_read_counter_if.slave bus
);

  localparam int TW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(SLEW_DIV + 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SLEW_DIV - 1);
  localparam logic [14:0]   STEP_INC    = 15'(SLEW_STEP);
  localparam logic [15:0]   STEP_LIMIT  = 16'(32768 / SLEW_STEP);
  localparam logic [14:0]   HALF_TURN   = 15'h4000;

  typedef enum logic [2:0] {
    ST_TRACK   = 3'd0,
    ST_QUAL    = 3'd1,
    ST_AMBIG   = 3'd2,
    ST_SLEW    = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   steps_q, steps_d;
  logic          err_q, err_d;
  logic [14:0]   count_q, count_d;
  logic          up_q, up_d;
  logic          dn_q, dn_d;
  logic [11:0]   dc_q, dc_d;
  logic          ambig_go;

`ifdef COARSE_AMBIG_EN
  assign ambig_go = bus._ADHI;
`else
  logic unused_adhi;
  assign unused_adhi = bus._ADHI;
  assign ambig_go    = 1'b0;
`endif

  // Bit k of the result drives _DC(k+1); octant picks the sine/cosine switch
  // pair, the next four count bits drive the resistor ladder.
  function automatic logic [11:0] dc_decode(input logic [14:0] c);
    logic [7:0] sw;
    unique case (c[14:12])
      3'd0:    sw = 8'b0001_0100;
      3'd1:    sw = 8'b0010_1000;
      3'd2:    sw = 8'b0010_0010;
      3'd3:    sw = 8'b0001_0001;
      3'd4:    sw = 8'b0100_0001;
      3'd5:    sw = 8'b1000_0010;
      3'd6:    sw = 8'b1000_1000;
      default: sw = 8'b0100_0100;
    endcase
    return {c[8], c[9], c[10], c[11], sw};
  endfunction

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    steps_d = steps_q;
    err_d   = err_q;
    count_d = count_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    unique case (state_q)
      ST_TRACK: begin
        if (bus.fine_up && !bus.fine_dn) begin
          count_d = count_q + 15'd1;
          up_d    = 1'b1;
        end else if (bus.fine_dn && !bus.fine_up) begin
          count_d = count_q - 15'd1;
          dn_d    = 1'b1;
        end
        if (bus._TLC1H) begin
          state_d = ST_QUAL;
          timer_d = '0;
          steps_d = '0;
        end
      end
      ST_QUAL: begin
        if (!bus._TLC1H) begin
          state_d = ST_TRACK;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ambig_go ? ST_AMBIG : ST_SLEW;
          timer_d = '0;
          div_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_AMBIG: begin
        count_d = count_q + HALF_TURN;
        up_d    = 1'b1;
        state_d = ST_QUAL;
        timer_d = '0;
      end
      ST_SLEW: begin
        if (!bus._TLC1H) begin
          state_d = ST_RECOVER;
          timer_d = '0;
        end else if (div_q == DIV_LAST) begin
          div_d   = '0;
          count_d = count_q + STEP_INC;
          up_d    = 1'b1;
          // Step count saturates at one revolution; the error flag is sticky.
          if (steps_q != STEP_LIMIT) begin
            steps_d = steps_q + 16'd1;
            if (steps_q + 16'd1 == STEP_LIMIT) err_d = 1'b1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_RECOVER: begin
        if (bus._TLC1H) begin
          state_d = ST_SLEW;
          div_d   = '0;
        end else if (timer_q == SETTLE_LAST) begin
          state_d = ST_TRACK;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_RECOVER;
        timer_d = '0;
      end
    endcase
    dc_d = dc_decode(count_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RECOVER;
      timer_q <= '0;
      div_q   <= '0;
      steps_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      dc_q    <= 12'h014;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      div_q   <= div_d;
      steps_q <= steps_d;
      err_q   <= err_d;
      count_q <= count_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      dc_q    <= dc_d;
    end
  end

  assign bus.count     = count_q;
  assign bus._CNTUP    = up_q;
  assign bus._CNTDN    = dn_q;
  assign bus.slewing   = (state_q != ST_TRACK);
  assign bus.slew_err  = err_q;
  assign bus.state_dbg = state_q;
  assign bus._DC1      = dc_q[0];
  assign bus._DC2      = dc_q[1];
  assign bus._DC3      = dc_q[2];
  assign bus._DC4      = dc_q[3];
  assign bus._DC5      = dc_q[4];
  assign bus._DC6      = dc_q[5];
  assign bus._DC7      = dc_q[6];
  assign bus._DC8      = dc_q[7];
  assign bus._DC9      = dc_q[8];
  assign bus._DC10     = dc_q[9];
  assign bus._DC11     = dc_q[10];
  assign bus._DC12     = dc_q[11];

endmodule

// File: tb/tb_coarse_read_counter.sv
// Randomised and directed bench for coarse_read_counter: a run-length reference
// model pushes expected count changes; a negedge monitor pops and compares.
module tb_coarse_read_counter;

  localparam int S     = 16;
  localparam int D     = 4;
  localparam int STEP  = 64;
  localparam int LIMIT = 32768 / STEP;
  localparam int W     = 17;
`ifdef COARSE_AMBIG_EN
  localparam bit AMBIG_ON = 1'b1;
`else
  localparam bit AMBIG_ON = 1'b0;
`endif
  localparam int SW_A [8] = '{3, 4, 2, 1, 1, 2, 4, 3};
  localparam int SW_B [8] = '{5, 6, 6, 5, 7, 8, 8, 7};

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coarse_read_counter_if bus ();

  coarse_read_counter #(
    .SETTLE_CYCLES(S),
    .SLEW_DIV     (D),
    .SLEW_STEP    (STEP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] ref_dc(input int c);
    logic [11:0] v;
    int oct;
    v   = '0;
    oct = (c >> 12) & 7;
    v[SW_A[oct] - 1] = 1'b1;
    v[SW_B[oct] - 1] = 1'b1;
    v[8]  = c[11];
    v[9]  = c[10];
    v[10] = c[9];
    v[11] = c[8];
    return v;
  endfunction

  function automatic logic [11:0] dut_dc();
    return {bus._DC12, bus._DC11, bus._DC10, bus._DC9, bus._DC8, bus._DC7,
            bus._DC6, bus._DC5, bus._DC4, bus._DC3, bus._DC2, bus._DC1};
  endfunction

  // ---------------- reference model ----------------
  // Mode plus run lengths: highs seen while qualifying, lows seen while
  // recovering, clocks since the last slew step, steps since the slew began.
  typedef enum int {M_TRACK, M_QUAL, M_AMBIG, M_SLEW, M_RECOVER} mode_t;
  mode_t m_mode  = M_RECOVER;
  int    m_cnt   = 0;
  int    m_run   = 0;
  int    m_ticks = 0;
  int    m_steps = 0;
  bit    m_err   = 1'b0;

  always @(posedge clk) begin : model
    int  nxt;
    bit  up, dn;
    if (!rst_n) begin
      m_mode = M_RECOVER; m_cnt = 0; m_run = 0; m_ticks = 0; m_steps = 0; m_err = 1'b0;
    end else begin
      nxt = m_cnt; up = 1'b0; dn = 1'b0;
      case (m_mode)
        M_TRACK: begin
          if (bus.fine_up != bus.fine_dn) begin
            up  = bus.fine_up;
            dn  = bus.fine_dn;
            nxt = (m_cnt + (bus.fine_up ? 1 : 32767)) % 32768;
          end
          if (bus._TLC1H) begin m_mode = M_QUAL; m_run = 0; m_steps = 0; end
        end
        M_QUAL: begin
          if (!bus._TLC1H) m_mode = M_TRACK;
          else begin
            m_run++;
            if (m_run == S) begin
              m_mode  = (AMBIG_ON && bus._ADHI) ? M_AMBIG : M_SLEW;
              m_ticks = 0;
            end
          end
        end
        M_AMBIG: begin
          nxt = (m_cnt + 16384) % 32768; up = 1'b1;
          m_mode = M_QUAL; m_run = 0;
        end
        M_SLEW: begin
          if (!bus._TLC1H) begin m_mode = M_RECOVER; m_run = 0; end
          else begin
            m_ticks++;
            if (m_ticks == D) begin
              m_ticks = 0;
              nxt = (m_cnt + STEP) % 32768; up = 1'b1;
              m_steps++;
              if (m_steps >= LIMIT) m_err = 1'b1;
            end
          end
        end
        default: begin
          if (bus._TLC1H) begin m_mode = M_SLEW; m_ticks = 0; end
          else begin
            m_run++;
            if (m_run == S) m_mode = M_TRACK;
          end
        end
      endcase
      if (up || dn) exp_q.push_back({up, dn, 15'(nxt)});
      m_cnt = nxt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int n_pulses = 0;

  always @(negedge clk) begin : monitor
    logic [W-1:0] got, exp;
    got = {bus._CNTUP, bus._CNTDN, bus.count};
    if (bus._CNTUP || bus._CNTDN) begin
      n_pulses++;
      if (exp_q.size() == 0) check(1'b0, "unexpected_pulse", 32'(got), 32'h0);
      else begin
        exp = exp_q.pop_front();
        check(got == exp, "pulse_dir_count", 32'(got), 32'(exp));
      end
    end else if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check(1'b0, "missing_pulse", 32'(got), 32'(exp));
    end
    check(bus.count == 15'(m_cnt), "count", 32'(bus.count), 32'(m_cnt));
    check(dut_dc() == ref_dc(m_cnt), "dc", 32'(dut_dc()), 32'(ref_dc(m_cnt)));
    check(bus.slewing == (m_mode != M_TRACK), "slewing", 32'(bus.slewing),
          32'(m_mode != M_TRACK));
    check(bus.slew_err == m_err, "slew_err", 32'(bus.slew_err), 32'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_fine(input logic up, input logic dn);
    bus.fine_up = up;
    bus.fine_dn = dn;
    tick(1);
    bus.fine_up = 1'b0;
    bus.fine_dn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(S + 2);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int bound;
    int run;
    bus.fine_up = 1'b0;
    bus.fine_dn = 1'b0;
    bus._TLC1H  = 1'b0;
    bus._ADHI   = 1'b0;
    tick(3);
    check(bus.count == 15'h0, "reset_count", 32'(bus.count), 32'h0);
    check(dut_dc() == 12'h014, "reset_dc", 32'(dut_dc()), 32'h014);
    check(bus.slewing == 1'b1, "reset_slewing", 32'(bus.slewing), 32'h1);
    check({bus._CNTUP, bus._CNTDN, bus.slew_err} == 3'b000, "reset_flags",
          32'({bus._CNTUP, bus._CNTDN, bus.slew_err}), 32'h0);
    rst_n = 1'b1;
    tick(S + 2);
    check(bus.slewing == 1'b0, "recover_to_track", 32'(bus.slewing), 32'h0);

    repeat (3) begin pulse_fine(1'b1, 1'b0); tick(1); end
    check(bus.count == 15'd3, "three_ups", 32'(bus.count), 32'd3);

    repeat (3) pulse_fine(1'b0, 1'b1);
    pulse_fine(1'b0, 1'b1);
    check(bus.count == 15'h7FFF, "wrap_down", 32'(bus.count), 32'h7FFF);
    check(bus._CNTDN == 1'b1, "wrap_down_pulse", 32'(bus._CNTDN), 32'h1);
    check(dut_dc() == 12'hF44, "wrap_down_dc", 32'(dut_dc()), 32'hF44);

    pulse_fine(1'b1, 1'b0);
    check(bus.count == 15'h0, "wrap_up", 32'(bus.count), 32'h0);
    repeat (4095) pulse_fine(1'b1, 1'b0);
    pulse_fine(1'b1, 1'b0);
    check(bus.count == 15'h1000, "octant_cross", 32'(bus.count), 32'h1000);
    check(dut_dc() == 12'h028, "octant_cross_dc", 32'(dut_dc()), 32'h028);

    pulse_fine(1'b1, 1'b1);
    check({bus._CNTUP, bus._CNTDN} == 2'b00, "both_no_pulse",
          32'({bus._CNTUP, bus._CNTDN}), 32'h0);
    check(bus.count == 15'h1000, "both_no_change", 32'(bus.count), 32'h1000);

    bus._TLC1H = 1'b1;
    tick(S - 1);
    bus._TLC1H = 1'b0;
    tick(3);
    check(bus.slewing == 1'b0, "short_coarse_no_slew", 32'(bus.slewing), 32'h0);
    check(bus.count == 15'h1000, "short_coarse_count", 32'(bus.count), 32'h1000);

    // Ambiguity: held coarse error with _ADHI from 0x0100.
    do_reset();
    repeat (256) pulse_fine(1'b1, 1'b0);
    bus._TLC1H = 1'b1;
    bus._ADHI  = 1'b1;
    tick(S + 3);
    bus._ADHI  = 1'b0;
    tick(S + 2 + 10 * D);
    check(bus.count[14] == AMBIG_ON, "ambig_jump", 32'(bus.count[14]), 32'(AMBIG_ON));
    check((bus.count[5:0] == 6'd0) && (bus.count[13:8] != 6'd1),
          "slew_steps_taken", 32'(bus.count), 32'h0100);
    bus._TLC1H = 1'b0;
    tick(S + 2);
    check(bus.slewing == 1'b0, "ambig_recovered", 32'(bus.slewing), 32'h0);

    // Reset mid-slew overrides held coarse error and fine request.
    bus._TLC1H = 1'b1;
    tick(S + 20);
    rst_n       = 1'b0;
    bus.fine_up = 1'b1;
    tick(1);
    check(bus.count == 15'h0, "midslew_reset_count", 32'(bus.count), 32'h0);
    check(bus._CNTUP == 1'b0, "midslew_reset_pulse", 32'(bus._CNTUP), 32'h0);
    check(dut_dc() == 12'h014, "midslew_reset_dc", 32'(dut_dc()), 32'h014);
    rst_n       = 1'b1;
    bus.fine_up = 1'b0;

    // Full revolution without null: 512 steps of 64 wrap back to zero.
    bound = LIMIT * D + S + 100;
    for (int i = 0; i < bound && !bus.slew_err; i++) tick(1);
    check(bus.slew_err == 1'b1, "slew_err_set", 32'(bus.slew_err), 32'h1);
    check(bus.count == 15'h0, "slew_err_wrap_count", 32'(bus.count), 32'h0);
    tick(5 * D);
    bus._TLC1H = 1'b0;
    tick(S + 2);
    check(bus.slew_err == 1'b1, "slew_err_sticky", 32'(bus.slew_err), 32'h1);

    // Random traffic with bursty coarse indications.
    do_reset();
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        bus._TLC1H = ~bus._TLC1H;
        run = $urandom_range(1, 40);
      end
      run--;
      bus._ADHI   = ($urandom_range(0, 1) == 1);
      bus.fine_up = ($urandom_range(0, 3) == 0);
      bus.fine_dn = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    bus.fine_up = 1'b0;
    bus.fine_dn = 1'b0;
    bus._TLC1H  = 1'b0;
    bus._ADHI   = 1'b0;
    tick(S + 5);
    @(negedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    check(n_pulses > 4000, "pulses_seen", 32'(n_pulses), 32'd4000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
